serial_frame_tx: RTL

//   Serial bit-stream transmitter that drives the 1-bit `in` input of the team's

---
 rtl/serial_frame_tx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: preamble, then data MSB-first, then a zero gap.
// Words are accepted through a valid/ready handshake, one frame at a time.
`timescale 1ns/1ps

module serial_frame_tx #(
  parameter int               DATA_W     = 8,
  parameter int               PRE_W      = 3,
  parameter logic [PRE_W-1:0] PREAMBLE   = 3'b110,
  parameter int               GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              out_valid,
  output logic              frame_done
);

  localparam int MAX_A   = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int MAX_B   = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int MAX_LEN = (MAX_B > 1) ? MAX_B : 1;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    GAP
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic [PRE_W-1:0]    r_pre;
  logic                r_out;
  logic                r_outValid;
  logic                r_frameDone;

  state_t              w_stateNext;
  logic [CNT_W-1:0]    w_cntNext;
  logic [DATA_W-1:0]   w_shiftNext;
  logic [PRE_W-1:0]    w_preNext;
  logic                w_outNext;
  logic                w_outValidNext;
  logic                w_frameDoneNext;
  logic                w_accept;

  assign in_ready   = (r_state == IDLE);
  assign w_accept   = in_valid & in_ready;
  assign out        = r_out;
  assign out_valid  = r_outValid;
  assign frame_done = r_frameDone;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_pre       <= '0;
      r_out       <= 1'b0;
      r_outValid  <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_cnt       <= w_cntNext;
      r_shift     <= w_shiftNext;
      r_pre       <= w_preNext;
      r_out       <= w_outNext;
      r_outValid  <= w_outValidNext;
      r_frameDone <= w_frameDoneNext;
    end
  end

  // Counter holds the number of cycles already spent in the current state.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_stateNext = PRE;
          w_cntNext   = '0;
        end
      end
      PRE: begin
        if (r_cnt == PRE_LAST) begin
          w_stateNext = DATA;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (r_cnt == DATA_LAST) begin
          w_stateNext = (GAP_CYCLES > 0) ? GAP : IDLE;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_stateNext = IDLE;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  // Outputs are registered from the upcoming state so the first preamble bit
  // appears on the acceptance edge itself.
  always_comb begin
    w_outNext       = 1'b0;
    w_outValidNext  = 1'b0;
    w_frameDoneNext = 1'b0;
    w_shiftNext     = r_shift;
    w_preNext       = r_pre;
    case (w_stateNext)
      PRE: begin
        w_outValidNext = 1'b1;
        if (r_state == IDLE) begin
          w_outNext   = PREAMBLE[PRE_W-1];
          w_preNext   = PREAMBLE << 1;
          w_shiftNext = in_data;
        end else begin
          w_outNext = r_pre[PRE_W-1];
          w_preNext = r_pre << 1;
        end
      end
      DATA: begin
        w_outValidNext  = 1'b1;
        w_outNext       = r_shift[DATA_W-1];
        w_shiftNext     = r_shift << 1;
        w_frameDoneNext = (w_cntNext == DATA_LAST);
      end
      default: begin
        w_outNext = 1'b0;
      end
    endcase
  end

endmodule
